// File: rtl/cnl_job_seq_pkg.sv
// cnl_job_seq_pkg: shared types and constants for the quad job sequencer
// Contents: sequencer state enum, buffered job descriptor struct, watchdog width.
// The descriptor id field is sized for the widest supported id; the top zero-extends into it.
package cnl_job_seq_pkg;
   localparam int C_WDOG_W   = 16;
   localparam int C_ID_MAX_W = 32;

   typedef enum logic [2:0] {
      S_IDLE, S_CFG, S_START, S_FETCH, S_FETCH_WAIT, S_RUN, S_ACK, S_DONE
   } job_seq_state_t;

   typedef struct packed {
      logic [127:0]          params;
      logic [127:0]          cfg_data;
      logic [1:0]            cfg_sel;
      logic [C_ID_MAX_W-1:0] id;
   } job_desc_t;
endpackage

// File: rtl/cnl_job_seq_desc_fifo.sv
// cnl_job_seq_desc_fifo: synchronous descriptor FIFO with registered full/empty flags
// Ports:
//   clk_if, rst_n     clock, asynchronous active-low reset (empties the FIFO)
//   push, wr_data     write request and descriptor; ignored while full
//   pop, rd_data      read request; rd_data always shows the current head
//   full, empty       registered occupancy flags
module cnl_job_seq_desc_fifo
   import cnl_job_seq_pkg::*;
#(
   parameter int C_DEPTH = 4
) (
   input  logic      clk_if,
   input  logic      rst_n,
   input  logic      push,
   input  job_desc_t wr_data,
   input  logic      pop,
   output job_desc_t rd_data,
   output logic      full,
   output logic      empty
);
   localparam int AW = $clog2(C_DEPTH);
   localparam int CW = AW + 1;

   job_desc_t     mem [C_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count, count_next;
   logic          do_push, do_pop;

   assign do_push    = push && !full;
   assign do_pop     = pop && !empty;
   assign count_next = count + CW'(do_push) - CW'(do_pop);
   assign rd_data    = mem[rd_ptr];

   // Flags are computed from the next occupancy so they stay registered.
   always_ff @(posedge clk_if or negedge rst_n)
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop) rd_ptr <= rd_ptr + AW'(1);
         count <= count_next;
         full  <= count_next == CW'(C_DEPTH);
         empty <= count_next == '0;
      end

   always_ff @(posedge clk_if)
      if (do_push) mem[wr_ptr] <= wr_data;
endmodule

// File: rtl/cnn_layer_accel_job_sequencer.sv
// cnn_layer_accel_job_sequencer: buffers job descriptors and runs them on one quad in order
// Ports:
//   clk_if, rst_n                               interface clock, asynchronous active-low reset
//   desc_valid/desc_ready, desc_*               descriptor intake (params, cfg word, cfg lane, id)
//   config_valid/config_accept/config_data      quad config channel, one-hot lane from desc_cfg_sel
//   job_start/job_accept/job_parameters         quad job-start channel
//   job_fetch_request/ack/complete              fetch handshake, ack is a single-cycle pulse
//   job_complete/job_complete_ack               completion handshake, ack held until complete drops
//   done_valid/done_id/done_status              per-job result pulse, status 1 = run watchdog expired
//   busy, jobs_done_count                       activity flag, wrapping count of successful jobs
module cnn_layer_accel_job_sequencer
   import cnl_job_seq_pkg::*;
#(
   parameter int C_DESC_DEPTH = 4,
   parameter int C_TIMEOUT    = 65535,
   parameter int C_ID_WIDTH   = 8
) (
   input  logic                  clk_if,
   input  logic                  rst_n,
   input  logic                  desc_valid,
   output logic                  desc_ready,
   input  logic [127:0]          desc_job_params,
   input  logic [127:0]          desc_cfg_data,
   input  logic [1:0]            desc_cfg_sel,
   input  logic [C_ID_WIDTH-1:0] desc_id,
   output logic [3:0]            config_valid,
   input  logic [3:0]            config_accept,
   output logic [127:0]          config_data,
   output logic                  job_start,
   input  logic                  job_accept,
   output logic [127:0]          job_parameters,
   input  logic                  job_fetch_request,
   output logic                  job_fetch_ack,
   input  logic                  job_fetch_complete,
   input  logic                  job_complete,
   output logic                  job_complete_ack,
   output logic                  done_valid,
   output logic [C_ID_WIDTH-1:0] done_id,
   output logic                  done_status,
   output logic                  busy,
   output logic [15:0]           jobs_done_count
);
   job_seq_state_t      state;
   job_desc_t           wr_desc, head, cur;
   logic                full, empty, timeout, unused_cur;
   logic [C_WDOG_W-1:0] wdog, wdog_inc;

   assign wr_desc    = '{params: desc_job_params, cfg_data: desc_cfg_data,
                         cfg_sel: desc_cfg_sel, id: C_ID_MAX_W'(desc_id)};
   assign desc_ready = !full;
   assign busy       = (state != S_IDLE) || !empty;
   assign wdog_inc   = (&wdog) ? wdog : wdog + C_WDOG_W'(1);
   assign timeout    = (C_TIMEOUT != 0) && (wdog_inc == C_WDOG_W'(C_TIMEOUT));
   // The config word is driven straight from the FIFO head, so the stored copy is not needed.
   assign unused_cur = ^{cur.cfg_data, cur.id};

   cnl_job_seq_desc_fifo #(.C_DEPTH(C_DESC_DEPTH)) u_fifo (
      .clk_if  (clk_if),
      .rst_n   (rst_n),
      .push    (desc_valid),
      .wr_data (wr_desc),
      .pop     (state == S_IDLE),
      .rd_data (head),
      .full    (full),
      .empty   (empty)
   );

   // done_valid is raised on the edge that enters DONE, so it is high for the DONE cycle only.
   always_ff @(posedge clk_if or negedge rst_n)
      if (!rst_n) begin
         state            <= S_IDLE;
         cur              <= '0;
         wdog             <= '0;
         config_valid     <= '0;
         config_data      <= '0;
         job_start        <= 1'b0;
         job_parameters   <= '0;
         job_fetch_ack    <= 1'b0;
         job_complete_ack <= 1'b0;
         done_valid       <= 1'b0;
         done_id          <= '0;
         done_status      <= 1'b0;
         jobs_done_count  <= '0;
      end else begin
         job_fetch_ack <= 1'b0;
         done_valid    <= 1'b0;
         case (state)
            S_IDLE: if (!empty) begin
               cur          <= head;
               config_valid <= 4'b0001 << head.cfg_sel;
               config_data  <= head.cfg_data;
               state        <= S_CFG;
            end
            S_CFG: if (config_accept[cur.cfg_sel]) begin
               config_valid   <= '0;
               job_start      <= 1'b1;
               job_parameters <= cur.params;
               state          <= S_START;
            end
            S_START: if (job_accept) begin
               job_start <= 1'b0;
               state     <= S_FETCH;
            end
            S_FETCH: if (job_fetch_request) begin
               job_fetch_ack <= 1'b1;
               state         <= S_FETCH_WAIT;
            end
            S_FETCH_WAIT: if (job_fetch_complete) begin
               wdog             <= '0;
               job_complete_ack <= job_complete;
               state            <= job_complete ? S_ACK : S_RUN;
            end
            S_RUN: begin
               wdog <= wdog_inc;
               if (job_complete) begin
                  job_complete_ack <= 1'b1;
                  state            <= S_ACK;
               end else if (timeout) begin
                  done_valid  <= 1'b1;
                  done_status <= 1'b1;
                  done_id     <= cur.id[C_ID_WIDTH-1:0];
                  state       <= S_DONE;
               end
            end
            S_ACK: if (!job_complete) begin
               job_complete_ack <= 1'b0;
               done_valid       <= 1'b1;
               done_status      <= 1'b0;
               done_id          <= cur.id[C_ID_WIDTH-1:0];
               jobs_done_count  <= jobs_done_count + 16'd1;
               state            <= S_DONE;
            end
            default: state <= S_IDLE;
         endcase
      end
endmodule

// File: tb/tb_cnn_layer_accel_job_sequencer.sv
// tb_cnn_layer_accel_job_sequencer: directed and randomized checks of the job sequencer against a job-level model
module tb_cnn_layer_accel_job_sequencer;
   import cnl_job_seq_pkg::*;

   localparam int DEPTH = 4;
   localparam int TMO   = 10;
   localparam int IDW   = 8;
   localparam int P_IDLE = 0, P_CFG = 1, P_START = 2, P_FETCH = 3, P_FWAIT = 4, P_RUN = 5, P_ACK = 6, P_DONE = 7;
   localparam logic [127:0] PAR1 = {16{8'hA5}};
   localparam logic [127:0] CFG1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

   logic           clk_if = 1'b0;
   logic           rst_n  = 1'b0;
   logic           desc_valid, desc_ready;
   logic [127:0]   desc_job_params, desc_cfg_data;
   logic [1:0]     desc_cfg_sel;
   logic [IDW-1:0] desc_id;
   logic [3:0]     config_valid, config_accept;
   logic [127:0]   config_data, job_parameters;
   logic           job_start, job_accept, job_fetch_request, job_fetch_ack, job_fetch_complete;
   logic           job_complete, job_complete_ack, done_valid, done_status, busy;
   logic [IDW-1:0] done_id;
   logic [15:0]    jobs_done_count;

   always #5 clk_if = ~clk_if;

   cnn_layer_accel_job_sequencer #(.C_DESC_DEPTH(DEPTH), .C_TIMEOUT(TMO), .C_ID_WIDTH(IDW)) dut (
      .clk_if(clk_if), .rst_n(rst_n),
      .desc_valid(desc_valid), .desc_ready(desc_ready),
      .desc_job_params(desc_job_params), .desc_cfg_data(desc_cfg_data),
      .desc_cfg_sel(desc_cfg_sel), .desc_id(desc_id),
      .config_valid(config_valid), .config_accept(config_accept), .config_data(config_data),
      .job_start(job_start), .job_accept(job_accept), .job_parameters(job_parameters),
      .job_fetch_request(job_fetch_request), .job_fetch_ack(job_fetch_ack),
      .job_fetch_complete(job_fetch_complete),
      .job_complete(job_complete), .job_complete_ack(job_complete_ack),
      .done_valid(done_valid), .done_id(done_id), .done_status(done_status),
      .busy(busy), .jobs_done_count(jobs_done_count)
   );

   int n_chk = 0;
   int n_fail = 0;

   // Job-level model: descriptors waiting, the job in flight and the outputs the rules demand.
   job_desc_t      mq[$];
   job_desc_t      m_cur;
   int             m_phase, m_wd;
   logic [3:0]     e_cv;
   logic [127:0]   e_cd, e_jp;
   logic           e_js, e_fa, e_ca, e_dv, e_ds;
   logic [IDW-1:0] e_did;
   logic [15:0]    e_cnt;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_cur = '0;
      m_phase = P_IDLE;
      m_wd = 0;
      e_cv = '0; e_cd = '0; e_jp = '0;
      e_js = 0; e_fa = 0; e_ca = 0; e_dv = 0; e_ds = 0;
      e_did = '0; e_cnt = '0;
   endtask

   task automatic finish_job(input logic st);
      e_dv = 1'b1;
      e_ds = st;
      e_did = m_cur.id[IDW-1:0];
      if (!st) e_cnt++;
      m_phase = P_DONE;
   endtask

   // Applies the inputs present now to the model, as the coming clock edge will.
   task automatic model_step();
      job_desc_t d;
      logic push;
      push = desc_valid && (mq.size() < DEPTH);
      d.params = desc_job_params;
      d.cfg_data = desc_cfg_data;
      d.cfg_sel = desc_cfg_sel;
      d.id = 32'(desc_id);
      e_fa = 1'b0;
      e_dv = 1'b0;
      case (m_phase)
         P_IDLE: if (mq.size() != 0) begin
            m_cur = mq.pop_front();
            e_cv = 4'b0001 << m_cur.cfg_sel;
            e_cd = m_cur.cfg_data;
            m_phase = P_CFG;
         end
         P_CFG: if (config_accept[m_cur.cfg_sel]) begin
            e_cv = '0; e_js = 1'b1; e_jp = m_cur.params; m_phase = P_START;
         end
         P_START: if (job_accept) begin
            e_js = 1'b0; m_phase = P_FETCH;
         end
         P_FETCH: if (job_fetch_request) begin
            e_fa = 1'b1; m_phase = P_FWAIT;
         end
         P_FWAIT: if (job_fetch_complete) begin
            m_wd = 0;
            e_ca = job_complete;
            m_phase = job_complete ? P_ACK : P_RUN;
         end
         P_RUN: begin
            m_wd++;
            if (job_complete) begin
               e_ca = 1'b1; m_phase = P_ACK;
            end else if (m_wd >= TMO) finish_job(1'b0 == 1'b0);
         end
         P_ACK: if (!job_complete) begin
            e_ca = 1'b0; finish_job(1'b0);
         end
         default: m_phase = P_IDLE;
      endcase
      if (push) mq.push_back(d);
   endtask

   task automatic check_all();
      chk("config_valid", config_valid, e_cv);
      if (e_cv != 0) chk("config_data", config_data, e_cd);
      chk("job_start", job_start, e_js);
      if (e_js) chk("job_parameters", job_parameters, e_jp);
      chk("job_fetch_ack", job_fetch_ack, e_fa);
      chk("job_complete_ack", job_complete_ack, e_ca);
      chk("done_valid", done_valid, e_dv);
      if (e_dv) begin
         chk("done_id", done_id, e_did);
         chk("done_status", done_status, e_ds);
      end
      chk("jobs_done_count", jobs_done_count, e_cnt);
      chk("desc_ready", desc_ready, mq.size() < DEPTH);
      chk("busy", busy, (m_phase != P_IDLE) || (mq.size() != 0));
   endtask

   task automatic cyc();
      model_step();
      @(posedge clk_if);
      @(negedge clk_if);
      check_all();
   endtask

   task automatic zero_inputs();
      desc_valid = 0; desc_job_params = '0; desc_cfg_data = '0; desc_cfg_sel = '0; desc_id = '0;
      config_accept = '0; job_accept = 0; job_fetch_request = 0; job_fetch_complete = 0; job_complete = 0;
   endtask

   task automatic rand_inputs(input logic allow_desc);
      desc_valid = allow_desc && ($urandom_range(99) < 30);
      desc_job_params = {$urandom, $urandom, $urandom, $urandom};
      desc_cfg_data = {$urandom, $urandom, $urandom, $urandom};
      desc_cfg_sel = 2'($urandom);
      desc_id = IDW'($urandom);
      config_accept = ($urandom_range(99) < 40) ? 4'($urandom) : 4'b0;
      job_accept = $urandom_range(99) < 40;
      job_fetch_request = $urandom_range(99) < 40;
      job_fetch_complete = $urandom_range(99) < 35;
      job_complete = $urandom_range(99) < 30;
   endtask

   task automatic push_desc(input logic [1:0] sel, input logic [IDW-1:0] id,
                            input logic [127:0] par, input logic [127:0] cfg);
      desc_valid = 1; desc_cfg_sel = sel; desc_id = id; desc_job_params = par; desc_cfg_data = cfg;
      cyc();
      desc_valid = 0;
   endtask

   task automatic to_fetch_wait(input logic [1:0] sel);
      config_accept = 4'b0001 << sel; cyc(); config_accept = '0;
      job_accept = 1; cyc(); job_accept = 0;
      job_fetch_request = 1; cyc(); job_fetch_request = 0;
   endtask

   initial begin
      #1000000;
      $display("FAIL global_timeout: bench did not reach its summary");
      $fatal(1);
   end

   initial begin
      int n, exp_id, guard;
      logic saw_ack, acc;
      zero_inputs();
      model_reset();
      repeat (2) @(negedge clk_if);
      chk("rst_desc_ready", desc_ready, 1'b1);
      chk("rst_config_valid", config_valid, 4'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_count", jobs_done_count, 16'd0);
      rst_n = 1;

      // Single job on lane 2, handshake by handshake.
      push_desc(2'd2, 8'h3C, PAR1, CFG1);
      chk("t1_busy_after_push", busy, 1'b1);
      chk("t1_cv_not_yet", config_valid, 4'b0);
      cyc();
      chk("t1_config_valid", config_valid, 4'b0100);
      chk("t1_config_data", config_data, CFG1);
      config_accept = 4'b1011; cyc();
      chk("t1_cv_other_lanes", config_valid, 4'b0100);
      config_accept = 4'b0100; cyc(); config_accept = '0;
      chk("t1_cv_dropped", config_valid, 4'b0);
      chk("t1_job_start", job_start, 1'b1);
      chk("t1_params", job_parameters, PAR1);
      job_accept = 1; cyc(); job_accept = 0;
      chk("t1_start_dropped", job_start, 1'b0);
      cyc();
      chk("t1_no_ack_without_req", job_fetch_ack, 1'b0);
      job_fetch_request = 1; cyc(); job_fetch_request = 0;
      chk("t1_fetch_ack", job_fetch_ack, 1'b1);
      cyc();
      chk("t1_fetch_ack_one_cycle", job_fetch_ack, 1'b0);
      job_fetch_complete = 1; cyc(); job_fetch_complete = 0;
      job_complete = 1; cyc();
      chk("t1_complete_ack", job_complete_ack, 1'b1);
      cyc();
      chk("t1_complete_ack_held", job_complete_ack, 1'b1);
      job_complete = 0; cyc();
      chk("t1_done_valid", done_valid, 1'b1);
      chk("t1_done_status", done_status, 1'b0);
      chk("t1_done_id", done_id, 8'h3C);
      chk("t1_count", jobs_done_count, 16'd1);
      chk("t1_ack_released", job_complete_ack, 1'b0);
      cyc();
      chk("t1_done_pulse", done_valid, 1'b0);

      // Watchdog: complete never arrives.
      push_desc(2'd0, 8'h77, 128'h1, 128'h2);
      cyc();
      to_fetch_wait(2'd0);
      job_fetch_complete = 1; cyc(); job_fetch_complete = 0;
      n = 0; saw_ack = 0;
      while (!done_valid && n < 40) begin
         cyc(); n++;
         if (job_complete_ack) saw_ack = 1;
      end
      chk("t2_timeout_cycles", n, 10);
      chk("t2_status", done_status, 1'b1);
      chk("t2_id", done_id, 8'h77);
      chk("t2_no_ack", saw_ack, 1'b0);
      chk("t2_count_unchanged", jobs_done_count, 16'd1);
      cyc();

      // Wrong-lane accept ignored, then fetch and job completion together.
      push_desc(2'd1, 8'h21, 128'h3, 128'h4);
      cyc();
      config_accept = 4'b0001;
      repeat (3) begin
         cyc();
         chk("t3_cv_held", config_valid, 4'b0010);
         chk("t3_no_start", job_start, 1'b0);
      end
      config_accept = '0;
      to_fetch_wait(2'd1);
      job_fetch_complete = 1; job_complete = 1; cyc();
      chk("t3_skip_run_ack", job_complete_ack, 1'b1);
      job_fetch_complete = 0; job_complete = 0; cyc();
      chk("t3_done", done_valid, 1'b1);
      chk("t3_status", done_status, 1'b0);
      chk("t3_count", jobs_done_count, 16'd2);
      cyc();

      // Five back-to-back descriptors while the first job waits in config.
      zero_inputs();
      n = 0; guard = 0;
      while (n < 5 && guard < 50) begin
         desc_valid = 1; desc_id = IDW'(n); desc_cfg_sel = 2'($urandom);
         desc_job_params = {$urandom, $urandom, $urandom, $urandom};
         desc_cfg_data = {$urandom, $urandom, $urandom, $urandom};
         acc = desc_ready;
         cyc();
         if (acc) n++;
         guard++;
      end
      chk("t4_all_pushed", n, 5);
      chk("t4_ready_low_full", desc_ready, 1'b0);
      desc_id = 8'hEE;
      repeat (2) cyc();
      chk("t4_ready_still_low", desc_ready, 1'b0);
      desc_valid = 0;
      exp_id = 0; guard = 0;
      while (exp_id < 5 && guard < 1000) begin
         rand_inputs(1'b0);
         cyc();
         if (done_valid) begin
            chk("t4_order", done_id, IDW'(exp_id));
            exp_id++;
         end
         guard++;
      end
      chk("t4_jobs_finished", exp_id, 5);

      // Randomized traffic against the model.
      repeat (3000) begin
         rand_inputs(1'b1);
         cyc();
      end

      // Drain, then reset in the middle of a running job with descriptors queued.
      guard = 0;
      while (busy && guard < 2000) begin
         rand_inputs(1'b0);
         cyc();
         guard++;
      end
      chk("t6_drained", busy, 1'b0);
      zero_inputs();
      push_desc(2'd3, 8'h55, 128'h5, 128'h6);
      cyc();
      push_desc(2'd0, 8'h56, 128'h7, 128'h8);
      push_desc(2'd1, 8'h57, 128'h9, 128'hA);
      to_fetch_wait(2'd3);
      job_fetch_complete = 1; cyc(); job_fetch_complete = 0;
      repeat (2) cyc();
      chk("t6_busy_in_run", busy, 1'b1);
      #2 rst_n = 0;
      #1;
      chk("t6_rst_config_valid", config_valid, 4'b0);
      chk("t6_rst_job_start", job_start, 1'b0);
      chk("t6_rst_fetch_ack", job_fetch_ack, 1'b0);
      chk("t6_rst_complete_ack", job_complete_ack, 1'b0);
      chk("t6_rst_done_valid", done_valid, 1'b0);
      chk("t6_rst_busy", busy, 1'b0);
      chk("t6_rst_desc_ready", desc_ready, 1'b1);
      chk("t6_rst_count", jobs_done_count, 16'd0);
      model_reset();
      zero_inputs();
      @(negedge clk_if);
      rst_n = 1;
      repeat (5) cyc();
      chk("t6_fifo_empty", busy, 1'b0);
      chk("t6_no_config", config_valid, 4'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
